ifetch_prefetch_queue: RTL and testbench

//  Parametrised fetch stage that replaces the fixed PC register / IF-DE register pair.

---
 rtl/ifetch_prefetch_queue_pkg.sv | 17 +
 rtl/ifetch_prefetch_queue_fifo.sv | 45 ++++
 rtl/ifetch_prefetch_queue.sv | 124 ++++++++++++
 tb/tb_ifetch_prefetch_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_prefetch_queue_pkg.sv
// rtl/ifetch_prefetch_queue_pkg.sv - shared fetch-stage widths, constants and queue entry layout
package ifetch_prefetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } ifq_entry_t;

    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_prefetch_queue_fifo.sv
// rtl/ifetch_prefetch_queue_fifo.sv - prefetch_fifo: sync FIFO with flush and occupancy
module prefetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     pop,
    output logic                     headValid,
    output logic [WIDTH-1:0]         headData,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty across wrap.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + (AW+1)'(1);
            if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wrPtr[AW-1:0]] <= wrData;
    end

    assign occupancy = wrPtr - rdPtr;
    assign headValid = (wrPtr != rdPtr);
    assign headData  = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// rtl/ifetch_prefetch_queue.sv - sequential fetch with ROM tag pipe, credit issue and prefetch queue
module ifetch_prefetch_queue #(
    parameter int XLEN = ifetch_prefetch_queue_pkg::XLEN,
    parameter int DEPTH = 4,
    parameter int ROM_LATENCY = 1,
    parameter logic [XLEN-1:0] RESET_PC = ifetch_prefetch_queue_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_FetchEn_1,
    input  logic                   i_Redirect_1,
    input  logic [XLEN-1:0]        i_RedirectAddr_32,
    output logic                   o_RomReq_1,
    output logic [XLEN-1:0]        o_RomAddr_32,
    input  logic [XLEN-1:0]        i_RomData_32,
    output logic                   o_InstValid_1,
    input  logic                   i_DecodeReady_1,
    output logic [XLEN-1:0]        o_Inst_32,
    output logic [XLEN-1:0]        o_PC_32,
    output logic [XLEN-1:0]        o_PCPlus4_32,
    output logic [$clog2(DEPTH):0] o_Occupancy
);

    import ifetch_prefetch_queue_pkg::*;

    localparam int OW = $clog2(DEPTH) + 1;
    localparam int CW = OW + 2;

    if (DEPTH < ROM_LATENCY + 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("DEPTH must be a power of 2 and at least ROM_LATENCY+2");
    end
    if (ROM_LATENCY < 1 || ROM_LATENCY > 2) begin : gBadLatency
        $error("ROM_LATENCY must be 1 or 2");
    end
    if (XLEN != $bits(ifq_entry_t) / 2) begin : gBadXlen
        $error("XLEN must match the queue entry width");
    end

    logic [XLEN-1:0]        fetchPc;
    logic [XLEN-1:0]        redirTarget;
    logic [ROM_LATENCY-1:0] tagValid;
    logic [XLEN-1:0]        tagPc [ROM_LATENCY];
    logic                   headValid;
    logic                   push;
    logic                   pop;
    logic                   romReq;
    logic                   canIssue;
    logic [OW-1:0]          occupancy;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          used;
    logic [2*XLEN-1:0]      headRaw;
    ifq_entry_t             headEntry;
    ifq_entry_t             wrEntry;

    assign redirTarget = alignWord(i_RedirectAddr_32);

    // A redirect kills the maturing read and hides the head in the same cycle.
    assign push          = tagValid[ROM_LATENCY-1] & ~i_Redirect_1;
    assign o_InstValid_1 = headValid & ~i_Redirect_1;
    assign pop           = o_InstValid_1 & i_DecodeReady_1;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + CW'(tagValid[i]);
        end
    end

    // Queue slots already spoken for; issuing only below DEPTH means a landing read always fits.
    assign used     = CW'(occupancy) + inflight - CW'(pop);
    assign canIssue = used < CW'(DEPTH);
    assign romReq   = ~rst & i_FetchEn_1 & (i_Redirect_1 | canIssue);

    assign o_RomReq_1   = romReq;
    assign o_RomAddr_32 = i_Redirect_1 ? redirTarget : fetchPc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc <= RESET_PC;
        end else if (i_Redirect_1) begin
            fetchPc <= romReq ? redirTarget + XLEN'(4) : redirTarget;
        end else if (romReq) begin
            fetchPc <= fetchPc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagValid <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) tagPc[i] <= '0;
        end else begin
            tagValid[0] <= romReq;
            tagPc[0]    <= o_RomAddr_32;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                tagValid[i] <= tagValid[i-1] & ~i_Redirect_1;
                tagPc[i]    <= tagPc[i-1];
            end
        end
    end

    assign wrEntry = {i_RomData_32, tagPc[ROM_LATENCY-1]};

    prefetch_fifo #(
        .WIDTH(2*XLEN),
        .DEPTH(DEPTH)
    ) uFifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_Redirect_1),
        .push      (push),
        .wrData    (wrEntry),
        .pop       (pop),
        .headValid (headValid),
        .headData  (headRaw),
        .occupancy (occupancy)
    );

    assign headEntry    = headRaw;
    assign o_Inst_32    = headValid ? headEntry.inst : INST_NOP;
    assign o_PC_32      = headEntry.pc;
    assign o_PCPlus4_32 = headEntry.pc + XLEN'(4);
    assign o_Occupancy  = occupancy;

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb/tb_ifetch_prefetch_queue.sv - scoreboard bench for ifetch_prefetch_queue at ROM latency 1 and 2
module tb_ifetch_prefetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, fetchEn, redirect, ready;
    logic [31:0] redirAddr;

    logic        romReq1, valid1, romReq2, valid2;
    logic [31:0] romAddr1, inst1, pc1, pcp1, romAddr2, inst2, pc2, pcp2;
    logic [31:0] romData1 = '0, romData2 = '0, romPipe2 = '0;
    logic [2:0]  occ1, occ2;

    ifetch_prefetch_queue #(.DEPTH(4), .ROM_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .i_FetchEn_1(fetchEn), .i_Redirect_1(redirect),
        .i_RedirectAddr_32(redirAddr), .o_RomReq_1(romReq1), .o_RomAddr_32(romAddr1),
        .i_RomData_32(romData1), .o_InstValid_1(valid1), .i_DecodeReady_1(ready),
        .o_Inst_32(inst1), .o_PC_32(pc1), .o_PCPlus4_32(pcp1), .o_Occupancy(occ1)
    );

    ifetch_prefetch_queue #(.DEPTH(4), .ROM_LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .i_FetchEn_1(fetchEn), .i_Redirect_1(redirect),
        .i_RedirectAddr_32(redirAddr), .o_RomReq_1(romReq2), .o_RomAddr_32(romAddr2),
        .i_RomData_32(romData2), .o_InstValid_1(valid2), .i_DecodeReady_1(ready),
        .o_Inst_32(inst2), .o_PC_32(pc2), .o_PCPlus4_32(pcp2), .o_Occupancy(occ2)
    );

    // ROM models: contents are addr ^ KEY, returned after one or two cycles.
    always @(posedge clk) begin
        romData1 <= romAddr1 ^ KEY;
        romPipe2 <= romAddr2 ^ KEY;
        romData2 <= romPipe2;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] expQ1 [$];
    logic [31:0] expQ2 [$];
    logic [31:0] mPc1 = 32'h0, mPc2 = 32'h0, e1, e2;

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (redirect) begin
                check("redirValid1", 32'(valid1), 32'd0);
                expQ1.delete();
                mPc1 = {redirAddr[31:2], 2'b00};
            end else if (valid1 && ready) begin
                checks++;
                assert (expQ1.size() != 0) else begin
                    errors++;
                    $error("FAIL pop1: observed pc %h expected no entry", pc1);
                end
                if (expQ1.size() != 0) begin
                    e1 = expQ1.pop_front();
                    check("pc1", pc1, e1);
                    check("inst1", inst1, e1 ^ KEY);
                    check("pcPlus4_1", pcp1, e1 + 32'd4);
                end
            end
            if (romReq1) begin
                check("romAddr1", romAddr1, mPc1);
                expQ1.push_back(mPc1);
                mPc1 = mPc1 + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (redirect) begin
                check("redirValid2", 32'(valid2), 32'd0);
                expQ2.delete();
                mPc2 = {redirAddr[31:2], 2'b00};
            end else if (valid2 && ready) begin
                checks++;
                assert (expQ2.size() != 0) else begin
                    errors++;
                    $error("FAIL pop2: observed pc %h expected no entry", pc2);
                end
                if (expQ2.size() != 0) begin
                    e2 = expQ2.pop_front();
                    check("pc2", pc2, e2);
                    check("inst2", inst2, e2 ^ KEY);
                    check("pcPlus4_2", pcp2, e2 + 32'd4);
                end
            end
            if (romReq2) begin
                check("romAddr2", romAddr2, mPc2);
                expQ2.push_back(mPc2);
                mPc2 = mPc2 + 32'd4;
            end
        end
    end

    int cnt1, cnt2;

    initial begin
        rst = 1'b1; fetchEn = 1'b1; redirect = 1'b0; redirAddr = '0; ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rstReq1", 32'(romReq1), 32'd0);
        check("rstValid1", 32'(valid1), 32'd0);
        check("rstOcc1", 32'(occ1), 32'd0);
        check("rstReq2", 32'(romReq2), 32'd0);

        // Release: request at RESET_PC in cycle 1, first valid in cycle 3 (cycle 4 at latency 2).
        @(negedge clk); rst = 1'b0; #1;
        check("c1Req1", 32'(romReq1), 32'd1);
        check("c1Addr1", romAddr1, 32'h0);
        @(negedge clk); #1;
        check("c2Valid1", 32'(valid1), 32'd0);
        @(negedge clk); #1;
        check("c3Valid1", 32'(valid1), 32'd1);
        check("c3Pc1", pc1, 32'h0);
        check("c3Valid2", 32'(valid2), 32'd0);
        @(negedge clk); #1;
        check("c4Valid2", 32'(valid2), 32'd1);
        check("c4Pc2", pc2, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            check("streamValid1", 32'(valid1), 32'd1);
        end

        // Build two queued + one in flight, then redirect to an unaligned target.
        @(negedge clk); ready = 1'b0; #1;
        @(negedge clk); ready = 1'b1; redirect = 1'b1; redirAddr = 32'h0000_0103; #1;
        check("preRedirOcc1", 32'(occ1), 32'd2);
        check("redirReq1", 32'(romReq1), 32'd1);
        check("redirAddr1", romAddr1, 32'h100);
        @(negedge clk); redirect = 1'b0; #1;
        check("postRedirValid1", 32'(valid1), 32'd0);
        @(negedge clk); #1;
        check("firstRedirValid1", 32'(valid1), 32'd1);
        check("firstRedirPc1", pc1, 32'h100);
        repeat (4) @(negedge clk);

        // Decode stalled from an emptied queue: credits allow exactly DEPTH requests.
        cnt1 = 0; cnt2 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); redirect = (i == 0); redirAddr = 32'h40; ready = 1'b0; #1;
            cnt1 += int'(romReq1);
            cnt2 += int'(romReq2);
        end
        check("stallReqs1", 32'(cnt1), 32'd4);
        check("stallReqs2", 32'(cnt2), 32'd4);
        check("stallOcc1", 32'(occ1), 32'd4);
        check("stallOcc2", 32'(occ2), 32'd4);
        check("stallReq1", 32'(romReq1), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); redirect = 1'b0; ready = 1'b1; #1;
            check("resumeValid1", 32'(valid1), 32'd1);
        end

        // Back-to-back redirects: only the second target's stream may appear.
        @(negedge clk); redirect = 1'b1; redirAddr = 32'h200; #1;
        @(negedge clk); redirAddr = 32'h300; #1;
        @(negedge clk); redirect = 1'b0; #1;
        check("dblValid2a", 32'(valid2), 32'd0);
        @(negedge clk); #1;
        check("dblValid2b", 32'(valid2), 32'd0);
        check("dblValid1", 32'(valid1), 32'd1);
        check("dblPc1", pc1, 32'h300);
        @(negedge clk); #1;
        check("dblValid2c", 32'(valid2), 32'd1);
        check("dblPc2", pc2, 32'h300);
        repeat (3) @(negedge clk);

        // Address wrap at the top of the space.
        @(negedge clk); redirect = 1'b1; redirAddr = 32'hFFFF_FFF8; #1;
        @(negedge clk); redirect = 1'b0; #1;
        @(negedge clk); #1;
        check("wrapPcA", pc1, 32'hFFFF_FFF8);
        @(negedge clk); #1;
        check("wrapPcB", pc1, 32'hFFFF_FFFC);
        check("wrapPcPlus4", pcp1, 32'h0);
        @(negedge clk); #1;
        check("wrapPcC", pc1, 32'h0);

        // Fetch disabled: no requests, queue drains; re-enable continues at FetchPC.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); fetchEn = 1'b0; #1;
            check("enOffReq1", 32'(romReq1), 32'd0);
            check("enOffReq2", 32'(romReq2), 32'd0);
        end
        check("drainOcc1", 32'(occ1), 32'd0);
        check("drainOcc2", 32'(occ2), 32'd0);
        @(negedge clk); fetchEn = 1'b1;
        repeat (6) @(negedge clk);

        // Fill the queue, then reset asynchronously mid-cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); ready = 1'b0;
        end
        #1;
        check("fullOcc1", 32'(occ1), 32'd4);
        check("fullOcc2", 32'(occ2), 32'd4);
        @(negedge clk); #3; rst = 1'b1; #1;
        check("asyncValid1", 32'(valid1), 32'd0);
        check("asyncOcc1", 32'(occ1), 32'd0);
        check("asyncReq1", 32'(romReq1), 32'd0);
        check("asyncValid2", 32'(valid2), 32'd0);
        check("asyncOcc2", 32'(occ2), 32'd0);
        expQ1.delete(); expQ2.delete();
        mPc1 = 32'h0; mPc2 = 32'h0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0; ready = 1'b1; #1;
        check("restartReq1", 32'(romReq1), 32'd1);
        check("restartAddr1", romAddr1, 32'h0);
        @(negedge clk);
        @(negedge clk); #1;
        check("restartValid1", 32'(valid1), 32'd1);
        check("restartPc1", pc1, 32'h0);
        repeat (10) @(negedge clk);

        fetchEn = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        check("finalQ1", 32'(expQ1.size()), 32'd0);
        check("finalQ2", 32'(expQ2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
